// File: rtl/fib_seq_param_if.sv
// Start/ready/done handshake and result bus of the Fibonacci engine.
// Latency: none (wires only).
// Backpressure: start is only taken while ready=1; results are qualified by done_tick.
// Signals: start, i, abort (requester -> engine); ready, done_tick, f, ovf (engine -> requester).
interface fib_seq_param_if #(
  parameter int W  = 32,
  parameter int IW = 6
);
  logic          start;
  logic [IW-1:0] i;
  logic          abort;
  logic          ready;
  logic          done_tick;
  logic [W-1:0]  f;
  logic          ovf;

  // Requester side.
  modport master (
    output start, i, abort,
    input  ready, done_tick, f, ovf
  );

  // Engine side.
  modport slave (
    input  start, i, abort,
    output ready, done_tick, f, ovf
  );
endinterface

// File: rtl/fib_seq_param.sv
// Iterative Fibonacci engine: f = F(i), one add per cycle, with overflow flag and wrap/saturate.
// Latency: start accepted at edge T -> done_tick in cycle T+max(i,1)+1 (OP lasts max(i,1) cycles).
// Backpressure: ready=1 only in IDLE; start outside IDLE is ignored, abort only acts in OP.
// Ports: clk, rst_n (async active-low); bus (slave modport): start, i, abort in;
//        ready, done_tick, f, ovf out. f/ovf hold the last completed job's result.
module fib_seq_param #(
  parameter int W   = 32,
  parameter int IW  = 6,
  parameter bit SAT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  fib_seq_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  t0;
  logic [W-1:0]  t1;
  logic [IW-1:0] n;
  logic          ovf_acc;
  logic [W-1:0]  f_q;
  logic          ovf_q;

  // One extra bit so the carry out of the W-bit add is visible.
  logic [W:0]    sum;

  assign sum = {1'b0, t1} + {1'b0, t0};

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.f         = f_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t0      <= '0;
      t1      <= '0;
      n       <= '0;
      ovf_acc <= 1'b0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort is deliberately not looked at here: start always wins in IDLE.
          if (bus.start) begin
            t0      <= '0;
            t1      <= W'(1);
            n       <= bus.i;
            ovf_acc <= 1'b0;
            state   <= OP;
          end
        end

        OP: begin
          if (bus.abort) begin
            // Cancelled job leaves f/ovf from the previous job untouched.
            state <= IDLE;
          end else if (n == '0) begin
            f_q   <= '0;
            ovf_q <= ovf_acc;
            state <= DONE;
          end else if (n == IW'(1)) begin
            f_q   <= t1;
            ovf_q <= ovf_acc;
            state <= DONE;
          end else begin
            // n only decrements while n>=2, so the maximum index never wraps the counter.
            t0 <= t1;
            n  <= n - IW'(1);
            if (sum[W]) begin
              ovf_acc <= 1'b1;
              // Once saturated, t1 stays all-ones: every later add carries again
              // because t0 is never zero after the first step.
              t1 <= SAT ? {W{1'b1}} : sum[W-1:0];
            end else begin
              t1 <= sum[W-1:0];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
